// File: rtl/gcd_controller_if.sv
// Control/status bundle between the GCD sequencer, its datapath and the requesting system.
// master = controller side (drives loads/selects/status), slave = datapath + system side.
interface gcd_controller_if #(
    parameter int ITER_W = 16
);
    logic              start;
    logic              Lt;
    logic              Gt;
    logic              Et;
    logic              lda;
    logic              ldb;
    logic              sel1;
    logic              sel2;
    logic              sel3;
    logic              busy;
    logic              done;
    logic              err;
    logic [ITER_W-1:0] iter_count;

    modport master (
        input  start, Lt, Gt, Et,
        output lda, ldb, sel1, sel2, sel3, busy, done, err, iter_count
    );

    modport slave (
        output start, Lt, Gt, Et,
        input  lda, ldb, sel1, sel2, sel3, busy, done, err, iter_count
    );
endinterface

// File: rtl/gcd_controller.sv
// Subtract-and-compare GCD sequencer: loads A then B from the data bus, then one subtraction per cycle until Et.
// done arrives 3+k cycles after start (k subtractions); start is ignored while busy, and there is no other backpressure.
module gcd_controller #(
    parameter int MAX_ITER = 65535,
    parameter int ITER_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    gcd_controller_if.master  ctl
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_B = 2'd1,
        CALC   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);
    localparam logic [ITER_W-1:0] ITER_ONE   = ITER_W'(1);

    state_t            state_q, state_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic              err_q, err_d;

    logic lda_d, ldb_d, sel1_d, sel2_d, sel3_d, busy_d, done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            iter_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            err_q   <= err_d;
        end
    end

    // Controls are gated by rst so the datapath sees no load in the reset cycle.
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        err_d   = err_q;
        lda_d   = 1'b0;
        ldb_d   = 1'b0;
        sel1_d  = 1'b0;
        sel2_d  = 1'b0;
        sel3_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (ctl.start) begin
                        lda_d   = 1'b1;
                        iter_d  = '0;
                        err_d   = 1'b0;
                        state_d = LOAD_B;
                    end
                end

                LOAD_B: begin
                    busy_d  = 1'b1;
                    ldb_d   = 1'b1;
                    state_d = CALC;
                end

                CALC: begin
                    busy_d = 1'b1;
                    if (ctl.Et) begin
                        state_d = DONE;
                    end else if (iter_q == ITER_LIMIT) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else if (ctl.Gt) begin
                        lda_d  = 1'b1;
                        sel2_d = 1'b1;
                        sel3_d = 1'b1;
                        iter_d = iter_q + ITER_ONE;
                    end else if (ctl.Lt) begin
                        ldb_d  = 1'b1;
                        sel1_d = 1'b1;
                        sel3_d = 1'b1;
                        iter_d = iter_q + ITER_ONE;
                    end else begin
                        // No comparator flag means a broken datapath; abort rather than spin.
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end

                DONE: begin
                    busy_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign ctl.lda        = lda_d;
    assign ctl.ldb        = ldb_d;
    assign ctl.sel1       = sel1_d;
    assign ctl.sel2       = sel2_d;
    assign ctl.sel3       = sel3_d;
    assign ctl.busy       = busy_d;
    assign ctl.done       = done_d;
    assign ctl.err        = err_q;
    assign ctl.iter_count = iter_q;

endmodule

// File: tb/tb_gcd_controller.sv
// Bench for gcd_controller: behavioural A/B datapath around the DUT, Euclid-based reference in a scoreboard.
module tb_gcd_controller;

    localparam int MAX_ITER = 8;
    localparam int ITER_W   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] data = '0;
    logic [15:0] reg_a = '0;
    logic [15:0] reg_b = '0;
    logic [15:0] minu, subt, bus_v;

    int n_vec = 0;
    int n_err = 0;
    int last_k = 0;
    int last_e = 0;

    typedef struct {
        int res;
        int k;
        int e;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    gcd_controller_if #(.ITER_W(ITER_W)) gif ();

    gcd_controller #(.MAX_ITER(MAX_ITER), .ITER_W(ITER_W)) dut (
        .clk (clk),
        .rst (rst),
        .ctl (gif)
    );

    // Datapath: subtractor, bus mux, A/B registers and comparator.
    always_comb begin
        minu  = gif.sel1 ? reg_b : reg_a;
        subt  = gif.sel2 ? reg_b : reg_a;
        bus_v = gif.sel3 ? (minu - subt) : data;
    end

    always @(posedge clk) begin
        if (gif.lda) reg_a <= bus_v;
        if (gif.ldb) reg_b <= bus_v;
    end

    assign gif.Lt = (reg_a < reg_b);
    assign gif.Gt = (reg_a > reg_b);
    assign gif.Et = (reg_a == reg_b);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Subtraction count = (sum of Euclid quotients) - 1; one zero operand never converges.
    function automatic exp_t model(input int a, input int b);
        exp_t r;
        int x, y, q, s;
        r.res = 0; r.k = 0; r.e = 0;
        if (a == 0 && b == 0) return r;
        if (a == 0 || b == 0) begin
            r.k = MAX_ITER; r.e = 1;
            return r;
        end
        x = a; y = b; s = 0;
        while (y != 0) begin
            q = x / y;
            s = s + q;
            q = x % y;
            x = y;
            y = q;
        end
        r.res = x;
        r.k   = s - 1;
        if (r.k > MAX_ITER) begin
            r.k = MAX_ITER; r.e = 1;
        end
        return r;
    endfunction

    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input bit toggle, input bit chk_sel);
        exp_t e;
        int   cyc;
        bit   seen;
        sb_q.push_back(model(int'(a), int'(b)));

        @(negedge clk); gif.start = 1'b1; data = a; #1;
        chk("c0_ctrl", {gif.lda, gif.ldb, gif.sel3, gif.busy, gif.done}, 5'b10000);
        @(negedge clk); gif.start = toggle; data = b; #1;
        chk("c1_ctrl", {gif.lda, gif.ldb, gif.sel3, gif.busy, gif.done}, 5'b01010);

        cyc  = 1;
        seen = 1'b0;
        while (!seen && cyc < 300) begin
            @(negedge clk);
            cyc++;
            gif.start = toggle;
            data = 16'($urandom);
            #1;
            if (gif.done) begin
                seen = 1'b1;
            end else begin
                chk("calc_busy", gif.busy, 1);
                if (chk_sel && cyc == 2)
                    chk("sel_c2", {gif.lda, gif.ldb, gif.sel1, gif.sel2, gif.sel3}, 5'b10011);
                if (chk_sel && cyc == 3)
                    chk("sel_c3", {gif.lda, gif.ldb, gif.sel1, gif.sel2, gif.sel3}, 5'b01101);
            end
        end
        chk("done_seen", gif.done, 1);

        if (seen) begin
            if (sb_q.size() == 0) begin
                chk("sb_nonempty", sb_q.size(), 1);
            end else begin
                e = sb_q.pop_front();
                chk("done_cycle", cyc, 3 + e.k);
                chk("done_busy", gif.busy, 1);
                chk("done_ctrl", {gif.lda, gif.ldb, gif.sel3}, 3'b000);
                chk("iter_count", gif.iter_count, e.k);
                chk("err", gif.err, e.e);
                if (e.e == 0) chk("result", reg_a, e.res);
                last_k = e.k;
                last_e = e.e;
            end
        end
    endtask

    task automatic idle_check();
        @(negedge clk); gif.start = 1'b0; data = 16'($urandom); #1;
        chk("idle_ctrl", {gif.lda, gif.ldb, gif.sel1, gif.sel2, gif.sel3, gif.busy, gif.done}, 7'b0);
        chk("idle_iter_hold", gif.iter_count, last_k);
        chk("idle_err_hold", gif.err, last_e);
    endtask

    initial begin
        gif.start = 1'b0;

        // Reset, with a start that must be ignored.
        @(negedge clk); rst = 1'b1; gif.start = 1'b1; data = 16'd99; #1;
        chk("rst_ctrl", {gif.lda, gif.ldb, gif.sel3, gif.busy, gif.done}, 5'b0);
        @(negedge clk); rst = 1'b0; gif.start = 1'b0; #1;
        chk("rst_busy", gif.busy, 0);
        chk("rst_iter", gif.iter_count, 0);
        chk("rst_err", gif.err, 0);
        idle_check();

        run_op(16'd12, 16'd8, 1'b0, 1'b1);
        idle_check();
        run_op(16'd35, 16'd14, 1'b0, 1'b0);
        idle_check();
        run_op(16'd7, 16'd7, 1'b0, 1'b0);
        run_op(16'd0, 16'd0, 1'b0, 1'b0);
        idle_check();

        run_op(16'd0, 16'd5, 1'b0, 1'b0);
        idle_check();
        run_op(16'd6, 16'd4, 1'b0, 1'b0);
        idle_check();

        // start toggling in LOAD_B/CALC/DONE, then a back-to-back start after done.
        run_op(16'd21, 16'd6, 1'b1, 1'b0);
        run_op(16'd9, 16'd6, 1'b1, 1'b0);
        idle_check();

        // Reset in the second CALC cycle of 12/8.
        @(negedge clk); gif.start = 1'b1; data = 16'd12;
        @(negedge clk); gif.start = 1'b0; data = 16'd8;
        @(negedge clk);
        @(negedge clk); rst = 1'b1; #1;
        chk("midrst_ctrl", {gif.lda, gif.ldb, gif.sel1, gif.sel2, gif.sel3, gif.busy, gif.done}, 7'b0);
        @(negedge clk); rst = 1'b0; #1;
        chk("midrst_after", {gif.lda, gif.ldb, gif.sel1, gif.sel2, gif.sel3, gif.busy, gif.done}, 7'b0);
        chk("midrst_iter", gif.iter_count, 0);
        chk("midrst_err", gif.err, 0);
        last_k = 0;
        last_e = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            chk("midrst_no_done", gif.done, 0);
        end

        run_op(16'd12, 16'd8, 1'b0, 1'b1);
        idle_check();
        chk("sb_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
